// File: rtl/perf_pkg.sv
// Shared types, read-select codes and helpers for the performance monitor.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DIVIDE,
    DONE
  } perf_state_t;

  localparam logic [2:0] SEL_CYCLES   = 3'd0;
  localparam logic [2:0] SEL_RETIRED  = 3'd1;
  localparam logic [2:0] SEL_STALLS   = 3'd2;
  localparam logic [2:0] SEL_FLUSHES  = 3'd3;
  localparam logic [2:0] SEL_CPI      = 3'd4;
  localparam logic [2:0] SEL_FINAL_PC = 3'd5;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input logic        en,
                                          input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (en && (value != max_val)) ? value + 64'd1 : value;
  endfunction

endpackage

// File: rtl/perf_serial_div.sv
// Restoring serial divider: one quotient bit per cycle, first bit resolved on the
// load edge so a DIVIDEND_W-bit divide completes after exactly DIVIDEND_W edges.
module perf_serial_div
  import perf_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = 40,
  parameter int unsigned QUOT_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [QUOT_W-1:0]     divisor,
  output logic                  busy,
  output logic                  done,
  output logic [QUOT_W-1:0]     quotient
);

  localparam int unsigned CNT_BITS = $clog2(DIVIDEND_W + 1);

  logic [QUOT_W-1:0]     rem_r;
  logic [DIVIDEND_W-1:0] shift_r;
  logic [CNT_BITS-1:0]   step_cnt;

  logic                  load;
  logic [QUOT_W-1:0]     rem_src;
  logic [DIVIDEND_W-1:0] shift_src;
  logic [QUOT_W:0]       trial;
  logic [QUOT_W:0]       diff;
  logic                  take;
  logic [QUOT_W-1:0]     rem_next;
  logic [DIVIDEND_W-1:0] shift_next;

  assign load = start && !busy;

  // shift_r carries the unconsumed dividend bits in its top and the quotient
  // bits accumulated so far in its bottom.
  always_comb begin
    rem_src    = load ? '0 : rem_r;
    shift_src  = load ? dividend : shift_r;
    trial      = {rem_src, shift_src[DIVIDEND_W-1]};
    diff       = trial - {1'b0, divisor};
    take       = ~diff[QUOT_W];
    rem_next   = take ? diff[QUOT_W-1:0] : trial[QUOT_W-1:0];
    shift_next = {shift_src[DIVIDEND_W-2:0], take};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_r    <= '0;
      shift_r  <= '0;
      step_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        if (divisor == '0) begin
          quotient <= '1;
          done     <= 1'b1;
        end else begin
          rem_r    <= rem_next;
          shift_r  <= shift_next;
          step_cnt <= CNT_BITS'(1);
          busy     <= 1'b1;
        end
      end else if (busy) begin
        rem_r    <= rem_next;
        shift_r  <= shift_next;
        step_cnt <= step_cnt + 1'b1;
        if (step_cnt == CNT_BITS'(DIVIDEND_W - 1)) begin
          busy     <= 1'b0;
          done     <= 1'b1;
          quotient <= (|shift_next[DIVIDEND_W-1:QUOT_W]) ? '1 : shift_next[QUOT_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/perf_monitor.sv
// Run-statistics monitor: counts cycles/retires/stalls/flushes until the fetch PC
// reaches PC_LIMIT, then derives fixed-point CPI; results via a registered read port.
module perf_monitor
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned PC_LIMIT = 400,
  parameter int unsigned FRAC_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      pc_if,
  input  logic             retire_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic             rd_req,
  input  logic [2:0]       rd_sel,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic             busy,
  output logic             done
);

  localparam int unsigned DIV_W = CNT_W + FRAC_W;

  perf_state_t state;

  logic [CNT_W-1:0] cycles, retired, stalls, flushes;
  logic [CNT_W-1:0] cpi_q, final_pc;
  logic [CNT_W-1:0] cycles_next, retired_next, stalls_next, flushes_next;
  logic [CNT_W-1:0] rd_mux;

  logic             at_limit;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [DIV_W-1:0] div_dividend;
  logic [CNT_W-1:0] div_quotient;

  assign cycles_next  = CNT_W'(sat_inc(64'(cycles),  1'b1,         CNT_W));
  assign retired_next = CNT_W'(sat_inc(64'(retired), retire_valid, CNT_W));
  assign stalls_next  = CNT_W'(sat_inc(64'(stalls),  stall,        CNT_W));
  assign flushes_next = CNT_W'(sat_inc(64'(flushes), flush,        CNT_W));

  assign at_limit = pc_if >= 32'(PC_LIMIT);

  // The divider is loaded from the post-increment counts on the final RUN edge,
  // so the last RUN cycle is included and DIVIDE spans exactly DIV_W cycles.
  assign div_start    = (state == RUN) && at_limit;
  assign div_dividend = {cycles_next, {FRAC_W{1'b0}}};

  perf_serial_div #(
    .DIVIDEND_W(DIV_W),
    .QUOT_W    (CNT_W)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .start   (div_start),
    .dividend(div_dividend),
    .divisor (retired_next),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quotient)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cycles   <= '0;
      retired  <= '0;
      stalls   <= '0;
      flushes  <= '0;
      cpi_q    <= '0;
      final_pc <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cycles  <= '0;
            retired <= '0;
            stalls  <= '0;
            flushes <= '0;
            cpi_q   <= '0;
            state   <= RUN;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        RUN: begin
          cycles  <= cycles_next;
          retired <= retired_next;
          stalls  <= stalls_next;
          flushes <= flushes_next;
          if (at_limit) begin
            final_pc <= CNT_W'(pc_if);
            state    <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (div_done && !div_busy) begin
            cpi_q <= div_quotient;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      SEL_CYCLES:   rd_mux = cycles;
      SEL_RETIRED:  rd_mux = retired;
      SEL_STALLS:   rd_mux = stalls;
      SEL_FLUSHES:  rd_mux = flushes;
      SEL_CPI:      rd_mux = cpi_q;
      SEL_FINAL_PC: rd_mux = final_pc;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data <= rd_mux;
      end
    end
  end

endmodule
